// File: rtl/axis_pkt_rr_arbiter.sv
// rtl/axis_pkt_rr_arbiter.sv - packet-level round-robin AXI-Stream arbiter
//
// Merges NUM_OF_INGRESS_PORTS ingress streams onto one egress stream. A grant
// is held from the first beat of a packet to its tlast, so packets never
// interleave. Each egress beat carries its source port on m_tuser.
// Optional feature macro: AXIS_ARB_PKT_LIMIT_EN (per-packet beat limit with
// truncation and discard of the packet tail).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   s_tvalid/s_tready      per-port ingress handshake (N bits)
//   s_tdata/s_tkeep        per-port ingress payload, port i at [i*W +: W]
//   s_tlast                per-port last beat
//   m_tvalid/m_tready      egress handshake
//   m_tdata/m_tkeep/m_tlast egress payload
//   m_tuser                source port index, upper bits zero
//   grant_vec              one-hot current grant, 0 while idle
//   pkt_cnt                per-port completed egress packet counters, 32 bits each
//   pkt_trunc              one-cycle pulse when a packet is truncated

module axis_pkt_rr_arbiter #(
   parameter int DATA_SIZE            = 32,
   parameter int USER_SIZE            = 16,
   parameter int NUM_OF_INGRESS_PORTS = 3,
   parameter int MAX_PKT_BEATS        = 1024
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_OF_INGRESS_PORTS-1:0]           s_tvalid,
   output logic [NUM_OF_INGRESS_PORTS-1:0]           s_tready,
   input  logic [NUM_OF_INGRESS_PORTS*DATA_SIZE-1:0] s_tdata,
   input  logic [NUM_OF_INGRESS_PORTS*DATA_SIZE/8-1:0] s_tkeep,
   input  logic [NUM_OF_INGRESS_PORTS-1:0]           s_tlast,
   output logic                                      m_tvalid,
   input  logic                                      m_tready,
   output logic [DATA_SIZE-1:0]                      m_tdata,
   output logic [DATA_SIZE/8-1:0]                    m_tkeep,
   output logic                                      m_tlast,
   output logic [USER_SIZE-1:0]                      m_tuser,
   output logic [NUM_OF_INGRESS_PORTS-1:0]           grant_vec,
   output logic [NUM_OF_INGRESS_PORTS*32-1:0]        pkt_cnt,
   output logic                                      pkt_trunc
);

   localparam int N         = NUM_OF_INGRESS_PORTS;
   localparam int PORT_W    = $clog2(NUM_OF_INGRESS_PORTS);
   localparam int KEEP_SIZE = DATA_SIZE / 8;

   // Elaboration-time sanity check of the configuration.
   if (N < 2 || N > 16 || MAX_PKT_BEATS < 1 || USER_SIZE < PORT_W) begin : g_bad_params
      $error("axis_pkt_rr_arbiter: unsupported parameter combination");
   end

`ifdef AXIS_ARB_PKT_LIMIT_EN
   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
`else
   typedef enum logic [0:0] {IDLE, BUSY} state_t;
`endif

   state_t              state_q, state_d;
   logic [PORT_W-1:0]   rr_ptr_q;
   logic [PORT_W-1:0]   grant_idx_q;
   logic [PORT_W-1:0]   sel_idx;
   logic [PORT_W-1:0]   next_ptr;
   logic [PORT_W:0]     cand;
   logic                sel_found;
   logic                src_vld;
   logic                src_last;
   logic                out_ready;
   logic                beat_xfer;
   logic                trunc_hit;
   logic                pkt_end;
   logic [31:0]         cnt_q [N];

   assign src_vld   = s_tvalid[grant_idx_q];
   assign src_last  = s_tlast[grant_idx_q];
   // Output register can take a new beat when empty or draining this cycle.
   assign out_ready = !m_tvalid || m_tready;
   assign beat_xfer = (state_q == BUSY) && src_vld && out_ready;
   assign next_ptr  = (grant_idx_q == PORT_W'(N - 1)) ? '0 : grant_idx_q + PORT_W'(1);
   assign pkt_end   = (state_q != IDLE) && (state_d == IDLE);

   // Round-robin search starting at rr_ptr, wrapping modulo N (N need not be
   // a power of two, so the wrap is explicit).
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, rr_ptr_q} + (PORT_W+1)'(k);
         if (cand >= (PORT_W+1)'(N)) begin
            cand = cand - (PORT_W+1)'(N);
         end
         if (!sel_found && s_tvalid[cand[PORT_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[PORT_W-1:0];
         end
      end
   end

`ifdef AXIS_ARB_PKT_LIMIT_EN
   localparam int BEAT_W = $clog2(MAX_PKT_BEATS + 1);
   logic [BEAT_W-1:0] beat_cnt_q;

   // Last allowed beat arrives without tlast: forward it as the packet end.
   assign trunc_hit = beat_xfer && !src_last && (beat_cnt_q == BEAT_W'(MAX_PKT_BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q <= '0;
         pkt_trunc  <= 1'b0;
      end else begin
         pkt_trunc <= trunc_hit;
         if (state_q == IDLE) begin
            beat_cnt_q <= '0;
         end else if (beat_xfer) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
         end
      end
   end
`else
   assign trunc_hit = 1'b0;
   assign pkt_trunc = 1'b0;
`endif

   always_comb begin
      s_tready = '0;
      if (state_q == BUSY) begin
         s_tready[grant_idx_q] = out_ready;
      end
`ifdef AXIS_ARB_PKT_LIMIT_EN
      else if (state_q == DRAIN) begin
         s_tready[grant_idx_q] = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (beat_xfer && src_last) begin
               state_d = IDLE;
            end
`ifdef AXIS_ARB_PKT_LIMIT_EN
            else if (trunc_hit) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Tail beats are swallowed until the real tlast.
            if (src_vld && src_last) begin
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         grant_idx_q <= '0;
         grant_vec   <= '0;
      end else if (state_q == IDLE && sel_found) begin
         grant_idx_q <= sel_idx;
         grant_vec   <= N'(1) << sel_idx;
      end else if (pkt_end) begin
         grant_vec <= '0;
         rr_ptr_q  <= next_ptr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
         m_tlast  <= 1'b0;
         m_tuser  <= '0;
      end else if (beat_xfer) begin
         m_tvalid <= 1'b1;
         m_tdata  <= s_tdata[grant_idx_q*DATA_SIZE +: DATA_SIZE];
         m_tkeep  <= s_tkeep[grant_idx_q*KEEP_SIZE +: KEEP_SIZE];
         m_tlast  <= src_last || trunc_hit;
         m_tuser  <= USER_SIZE'(grant_idx_q);
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

   // Packets are counted as they leave, attributed via the tag on m_tuser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (m_tvalid && m_tready && m_tlast) begin
         for (int i = 0; i < N; i++) begin
            if (m_tuser[PORT_W-1:0] == PORT_W'(i)) begin
               cnt_q[i] <= cnt_q[i] + 32'd1;
            end
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_cnt
      assign pkt_cnt[i*32 +: 32] = cnt_q[i];
   end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// tb/tb_axis_pkt_rr_arbiter.sv - self-checking bench for axis_pkt_rr_arbiter

module tb_axis_pkt_rr_arbiter;

   localparam int DW   = 32;
   localparam int UW   = 16;
   localparam int NP   = 3;
   localparam int MAXB = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NP-1:0]     s_tvalid;
   logic [NP-1:0]     s_tready;
   logic [NP*DW-1:0]  s_tdata;
   logic [NP*DW/8-1:0] s_tkeep;
   logic [NP-1:0]     s_tlast;
   logic              m_tvalid;
   logic              m_tready;
   logic [DW-1:0]     m_tdata;
   logic [DW/8-1:0]   m_tkeep;
   logic              m_tlast;
   logic [UW-1:0]     m_tuser;
   logic [NP-1:0]     grant_vec;
   logic [NP*32-1:0]  pkt_cnt;
   logic              pkt_trunc;

   always #5 clk = ~clk;

   axis_pkt_rr_arbiter #(
      .DATA_SIZE(DW), .USER_SIZE(UW), .NUM_OF_INGRESS_PORTS(NP), .MAX_PKT_BEATS(MAXB)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tlast(m_tlast), .m_tuser(m_tuser),
      .grant_vec(grant_vec), .pkt_cnt(pkt_cnt), .pkt_trunc(pkt_trunc)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] keep_of(input int p);
      return (p == 0) ? 4'h1 : (p == 1) ? 4'h3 : 4'h7;
   endfunction

   typedef struct {
      logic [2:0]  vld;
      logic [2:0]  lst;
      logic [31:0] d0, d1, d2;
      logic        rdy;
      logic [2:0]  e_srdy;
      logic        e_mv;
      logic [31:0] e_md;
      logic        e_ml;
      logic [1:0]  e_mu;
      logic [2:0]  e_gv;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        l;
      logic [15:0] u;
      logic [3:0]  k;
   } beat_t;

   vec_t  tbl[13];
   beat_t eg_q[$];

   int          src_len[NP];
   int          src_left[NP];
   int          src_idx[NP];
   logic [31:0] src_base[NP];
   int          hs_cnt[NP];
   logic [NP-1:0] hs;
   logic        rdy_drv;
   int          trunc_seen;

   task automatic set_src(input int p, input int len, input int npkts, input logic [31:0] base);
      src_len[p]  = len;
      src_left[p] = npkts;
      src_idx[p]  = 0;
      src_base[p] = base;
      hs[p]       = 1'b0;
   endtask

   // One clock: advance sources on last handshake, drive, sample before edge.
   task automatic cycle();
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
         if (hs[p]) begin
            hs_cnt[p]++;
            if (src_idx[p] == src_len[p] - 1) begin
               src_idx[p]  = 0;
               src_left[p] = src_left[p] - 1;
               src_base[p] = src_base[p] + 32'h10;
            end else begin
               src_idx[p]++;
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         s_tvalid[p]          = (src_left[p] > 0);
         s_tdata[p*DW +: DW]  = src_base[p] + 32'(src_idx[p]);
         s_tlast[p]           = (src_idx[p] == src_len[p] - 1);
      end
      m_tready = rdy_drv;
      #1;
      hs = s_tvalid & s_tready;
      if (m_tvalid && m_tready) eg_q.push_back('{m_tdata, m_tlast, m_tuser, m_tkeep});
      if (pkt_trunc) trunc_seen++;
   endtask

   task automatic check_beat(input int i, input logic [31:0] d, input logic l, input int u);
      if (i >= eg_q.size()) begin
         n_chk++;
         n_fail++;
         $display("FAIL beat%0d missing: got %0d beats, expected at least %0d", i, eg_q.size(), i + 1);
      end else begin
         chk($sformatf("beat%0d data", i), eg_q[i].d, d);
         chk($sformatf("beat%0d last", i), 32'(eg_q[i].l), 32'(l));
         chk($sformatf("beat%0d user", i), 32'(eg_q[i].u), 32'(u));
         chk($sformatf("beat%0d keep", i), 32'(eg_q[i].k), 32'(keep_of(u)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      int start;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = 12'h731; m_tready = 1'b0;
      rdy_drv = 1'b1; hs = '0; trunc_seen = 0;
      for (int p = 0; p < NP; p++) begin
         src_len[p] = 1; src_left[p] = 0; src_idx[p] = 0; src_base[p] = '0; hs_cnt[p] = 0;
      end

      // vld    lst    d0      d1      d2      rdy | srdy  mv  md      ml  mu  gv
      tbl[0]  = '{3'b010, 3'b000, 32'h0,  32'hA0, 32'h0,  1'b1, 3'b000, 1'b0, 32'h0,  1'b0, 2'd0, 3'b000};
      tbl[1]  = '{3'b010, 3'b000, 32'h0,  32'hA0, 32'h0,  1'b1, 3'b010, 1'b0, 32'h0,  1'b0, 2'd0, 3'b010};
      tbl[2]  = '{3'b010, 3'b000, 32'h0,  32'hA1, 32'h0,  1'b1, 3'b010, 1'b1, 32'hA0, 1'b0, 2'd1, 3'b010};
      tbl[3]  = '{3'b010, 3'b000, 32'h0,  32'hA2, 32'h0,  1'b1, 3'b010, 1'b1, 32'hA1, 1'b0, 2'd1, 3'b010};
      tbl[4]  = '{3'b010, 3'b010, 32'h0,  32'hA3, 32'h0,  1'b1, 3'b010, 1'b1, 32'hA2, 1'b0, 2'd1, 3'b010};
      tbl[5]  = '{3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  1'b1, 3'b000, 1'b1, 32'hA3, 1'b1, 2'd1, 3'b000};
      tbl[6]  = '{3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  1'b1, 3'b000, 1'b0, 32'h0,  1'b0, 2'd0, 3'b000};
      tbl[7]  = '{3'b101, 3'b101, 32'hB0, 32'h0,  32'hC0, 1'b1, 3'b000, 1'b0, 32'h0,  1'b0, 2'd0, 3'b000};
      tbl[8]  = '{3'b101, 3'b101, 32'hB0, 32'h0,  32'hC0, 1'b1, 3'b100, 1'b0, 32'h0,  1'b0, 2'd0, 3'b100};
      tbl[9]  = '{3'b001, 3'b001, 32'hB0, 32'h0,  32'h0,  1'b1, 3'b000, 1'b1, 32'hC0, 1'b1, 2'd2, 3'b000};
      tbl[10] = '{3'b001, 3'b001, 32'hB0, 32'h0,  32'h0,  1'b1, 3'b001, 1'b0, 32'h0,  1'b0, 2'd0, 3'b001};
      tbl[11] = '{3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  1'b1, 3'b000, 1'b1, 32'hB0, 1'b1, 2'd0, 3'b000};
      tbl[12] = '{3'b000, 3'b000, 32'h0,  32'h0,  32'h0,  1'b1, 3'b000, 1'b0, 32'h0,  1'b0, 2'd0, 3'b000};

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset m_tvalid", 32'(m_tvalid), 32'd0);
      chk("reset m_tdata", m_tdata, 32'd0);
      chk("reset m_tkeep", 32'(m_tkeep), 32'd0);
      chk("reset m_tlast", 32'(m_tlast), 32'd0);
      chk("reset m_tuser", 32'(m_tuser), 32'd0);
      chk("reset grant_vec", 32'(grant_vec), 32'd0);
      chk("reset s_tready", 32'(s_tready), 32'd0);
      chk("reset pkt_trunc", 32'(pkt_trunc), 32'd0);
      for (int p = 0; p < NP; p++) chk($sformatf("reset pkt_cnt%0d", p), pkt_cnt[p*32 +: 32], 32'd0);

      // Table: port1 4-beat packet, then port2/port0 back-to-back single beats
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         s_tvalid = tbl[i].vld;
         s_tlast  = tbl[i].lst;
         s_tdata  = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
         m_tready = tbl[i].rdy;
         #1;
         chk($sformatf("row%0d s_tready", i), 32'(s_tready), 32'(tbl[i].e_srdy));
         chk($sformatf("row%0d m_tvalid", i), 32'(m_tvalid), 32'(tbl[i].e_mv));
         chk($sformatf("row%0d grant_vec", i), 32'(grant_vec), 32'(tbl[i].e_gv));
         if (tbl[i].e_mv) begin
            chk($sformatf("row%0d m_tdata", i), m_tdata, tbl[i].e_md);
            chk($sformatf("row%0d m_tlast", i), 32'(m_tlast), 32'(tbl[i].e_ml));
            chk($sformatf("row%0d m_tuser", i), 32'(m_tuser), 32'(tbl[i].e_mu));
            chk($sformatf("row%0d m_tkeep", i), 32'(m_tkeep), 32'(keep_of(int'(tbl[i].e_mu))));
         end
      end
      for (int p = 0; p < NP; p++) chk($sformatf("table pkt_cnt%0d", p), pkt_cnt[p*32 +: 32], 32'd1);

      // Egress stall of 5 cycles mid-packet (4 beats = MAX_PKT_BEATS with tlast)
      eg_q.delete();
      set_src(1, 4, 1, 32'hD0);
      rdy_drv = 1'b1;
      guard = 0;
      while (eg_q.size() < 1 && guard < 50) begin cycle(); guard++; end
      rdy_drv = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cycle();
         chk($sformatf("stall%0d m_tvalid", c), 32'(m_tvalid), 32'd1);
         chk($sformatf("stall%0d m_tdata", c), m_tdata, 32'hD1);
         chk($sformatf("stall%0d m_tlast", c), 32'(m_tlast), 32'd0);
         chk($sformatf("stall%0d s_tready", c), 32'(s_tready), 32'd0);
      end
      rdy_drv = 1'b1;
      guard = 0;
      while (eg_q.size() < 4 && guard < 50) begin cycle(); guard++; end
      cycle();
      chk("stall beat count", eg_q.size(), 32'd4);
      for (int b = 0; b < 4; b++) check_beat(b, 32'hD0 + 32'(b), b == 3, 1);
      chk("stall pkt_cnt1", pkt_cnt[32 +: 32], 32'd2);

      // Asynchronous reset during beat 3 of a 6-beat packet from port2
      eg_q.delete();
      set_src(2, 6, 1, 32'hE0);
      guard = 0;
      while (!(m_tvalid && m_tdata == 32'hE2) && guard < 50) begin cycle(); guard++; end
      chk("reset-test reached beat3", 32'(m_tvalid && m_tdata == 32'hE2), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset m_tvalid", 32'(m_tvalid), 32'd0);
      chk("async reset grant_vec", 32'(grant_vec), 32'd0);
      chk("async reset s_tready", 32'(s_tready), 32'd0);
      chk("async reset pkt_cnt1", pkt_cnt[32 +: 32], 32'd0);
      src_left[2] = 0;
      hs = '0;
      s_tvalid = '0;
      @(negedge clk);
      @(negedge clk);
      #3 rst_n = 1'b1;
      eg_q.delete();
      repeat (3) cycle();
      chk("post-reset idle m_tvalid", 32'(m_tvalid), 32'd0);
      chk("post-reset idle beats", eg_q.size(), 32'd0);

      // Fairness: all ports continuously request two 2-beat packets each
      for (int p = 0; p < NP; p++) set_src(p, 2, 2, 32'(p + 1) << 8);
      guard = 0;
      while (eg_q.size() < 12 && guard < 200) begin cycle(); guard++; end
      cycle();
      chk("rr beat count", eg_q.size(), 32'd12);
      for (int k = 0; k < 6; k++) begin
         for (int b = 0; b < 2; b++) begin
            check_beat(2 * k + b, (32'((k % 3) + 1) << 8) + 32'(16 * (k / 3)) + 32'(b), b == 1, k % 3);
         end
      end
      for (int p = 0; p < NP; p++) chk($sformatf("rr pkt_cnt%0d", p), pkt_cnt[p*32 +: 32], 32'd2);
      chk("rr grant idle", 32'(grant_vec), 32'd0);
      chk("no truncation so far", 32'(trunc_seen), 32'd0);

`ifdef AXIS_ARB_PKT_LIMIT_EN
      // Port0 sends 7 beats with a 4-beat limit
      eg_q.delete();
      trunc_seen = 0;
      start = hs_cnt[0];
      set_src(0, 7, 1, 32'h700);
      guard = 0;
      while ((hs_cnt[0] - start < 7 || grant_vec != '0 || m_tvalid) && guard < 100) begin
         cycle();
         guard++;
      end
      chk("trunc accepted beats", 32'(hs_cnt[0] - start), 32'd7);
      chk("trunc forwarded beats", eg_q.size(), 32'd4);
      for (int b = 0; b < 4; b++) check_beat(b, 32'h700 + 32'(b), b == 3, 0);
      chk("trunc pulse count", 32'(trunc_seen), 32'd1);
      chk("trunc pkt_cnt0", pkt_cnt[0 +: 32], 32'd3);
      chk("trunc grant idle", 32'(grant_vec), 32'd0);
`else
      start = 0;
      repeat (3) cycle();
      chk("pkt_trunc tied low", 32'(trunc_seen + start), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
